// File: rtl/synapse_frame_loader.sv
// Serial-to-parallel ROWSxCOLS phase-word loader with a shadow register and atomic commit.
// Optional even-parity trailer bit enabled by SYNAPSE_FRAME_PARITY_EN.
module synapse_frame_loader #(
  parameter  int ROWS  = 5,
  parameter  int COLS  = 3,
  parameter  int W     = 4,
  localparam int N     = ROWS * COLS,
  localparam int TOTAL = N * W,
  localparam int EIW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [0:TOTAL-1] phi_out,
  output logic             frame_done,
  output logic             busy,
  output logic [EIW-1:0]   elem_idx,
  output logic             parity_err
);

  localparam int WCW = (W > 1) ? $clog2(W) : 1;
  localparam int PW  = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
`ifdef SYNAPSE_FRAME_PARITY_EN
    ,
    S_CHECK  = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [EIW-1:0]   elem_q, elem_d;
  logic [0:TOTAL-1] shadow_q;
  logic [0:TOTAL-1] phi_q;
  logic             done_q;
  logic             sh_we;
  logic             commit;
  logic [PW-1:0]    pos;
  logic             last_w;
  logic             last_bit;

  // Bit position inside the shadow frame, MSB of element 0 at index 0
  assign pos      = PW'(elem_q) * PW'(W) + PW'(wcnt_q);
  assign last_w   = (wcnt_q == WCW'(W - 1));
  assign last_bit = last_w && (elem_q == EIW'(N - 1));

`ifdef SYNAPSE_FRAME_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    elem_d  = elem_q;
    sh_we   = 1'b0;
    commit  = 1'b0;
`ifdef SYNAPSE_FRAME_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          wcnt_d  = '0;
          elem_d  = '0;
`ifdef SYNAPSE_FRAME_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (start) begin
          wcnt_d = '0;
          elem_d = '0;
`ifdef SYNAPSE_FRAME_PARITY_EN
          par_d  = 1'b0;
`endif
        end else if (bit_valid) begin
          sh_we = 1'b1;
`ifdef SYNAPSE_FRAME_PARITY_EN
          par_d = par_q ^ bit_in;
`endif
          if (last_bit) begin
            wcnt_d = '0;
            elem_d = '0;
`ifdef SYNAPSE_FRAME_PARITY_EN
            state_d = S_CHECK;
`else
            state_d = S_COMMIT;
`endif
          end else if (last_w) begin
            wcnt_d = '0;
            elem_d = elem_q + 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
`ifdef SYNAPSE_FRAME_PARITY_EN
      S_CHECK: begin
        if (start) begin
          state_d = S_LOAD;
          wcnt_d  = '0;
          elem_d  = '0;
          par_d   = 1'b0;
        end else if (bit_valid) begin
          if (par_q ^ bit_in) begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_COMMIT;
          end
        end
      end
`endif
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      elem_q   <= '0;
      shadow_q <= '0;
      phi_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      elem_q  <= elem_d;
      done_q  <= commit;
      if (sh_we) shadow_q[pos] <= bit_in;
      if (commit) phi_q <= shadow_q;
    end
  end

`ifdef SYNAPSE_FRAME_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign phi_out    = phi_q;
  assign frame_done = done_q;
  assign busy       = (state_q != S_IDLE);
  assign elem_idx   = elem_q;

endmodule

// File: tb/tb_synapse_frame_loader.sv
// Bench for synapse_frame_loader: vector table, corner sequences, random frames vs model.
// Parity trailer bits are sent when SYNAPSE_FRAME_PARITY_EN is defined.
module tb_synapse_frame_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        bit_valid;
  logic        bit_in;
  logic [0:59] phi_out;
  logic        frame_done;
  logic        busy;
  logic [3:0]  elem_idx;
  logic        parity_err;

  synapse_frame_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .phi_out    (phi_out),
    .frame_done (frame_done),
    .busy       (busy),
    .elem_idx   (elem_idx),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [59:0] phi_v;
  assign phi_v = phi_out;

  localparam logic [59:0] FA = 60'h00F00F00F00F00F;
  localparam logic [59:0] FB = 60'hFFFFFFFFFFFFFFF;
  localparam logic [59:0] FC = 60'h123456789ABCDEF;

  typedef struct {
    logic [59:0] frame;
    bit          gap;
    int          restart_at;
    logic [59:0] exp;
  } vec_t;

  vec_t        tbl [4];
  int          checks;
  int          errors;
  logic [59:0] model_phi;
  logic [59:0] fr;
  int          n;
  bit          bv;
  bit          b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic send_bits(input logic [59:0] f, input int cnt, input bit gap);
    for (int i = 0; i < cnt; i++) begin
      if (gap && i > 0) begin
        bit_valid = 1'b0;
        tick();
      end
      if (i % 4 == 0) check("elem_idx", elem_idx, i / 4);
      bit_valid = 1'b1;
      bit_in    = f[59-i];
      tick();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
    end
  endtask

  task automatic send_parity(input logic [59:0] f, input bit bad);
`ifdef SYNAPSE_FRAME_PARITY_EN
    check("busy_check", busy, 1);
    bit_valid = 1'b1;
    bit_in    = (^f) ^ bad;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
`else
    if (bad) check("no_parity_build", parity_err, 0);
`endif
  endtask

  task automatic run_frame(input logic [59:0] f, input bit gap,
                           input int rs, input logic [59:0] exp);
    logic [59:0] prev;
    prev  = model_phi;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (rs > 0) begin
      send_bits(f, rs, 1'b0);
      check("phi_partial", phi_v, prev);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_idx", elem_idx, 0);
      check("restart_busy", busy, 1);
    end
    send_bits(f, 60, gap);
    send_parity(f, 1'b0);
    check("phi_hold", phi_v, prev);
    check("done_early", frame_done, 0);
    check("busy_commit", busy, 1);
    tick();
    check("phi_commit", phi_v, exp);
    check("done_pulse", frame_done, 1);
    check("busy_drop", busy, 0);
    check("perr_good", parity_err, 0);
    tick();
    check("done_once", frame_done, 0);
    model_phi = exp;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{frame: FA, gap: 1'b0, restart_at: 0,  exp: FA};
    tbl[1] = '{frame: FA, gap: 1'b1, restart_at: 0,  exp: FA};
    tbl[2] = '{frame: FB, gap: 1'b0, restart_at: 20, exp: FB};
    tbl[3] = '{frame: FC, gap: 1'b1, restart_at: 7,  exp: FC};
    checks    = 0;
    errors    = 0;
    model_phi = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    repeat (3) tick();
    check("rst_phi", phi_v, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_idx", elem_idx, 0);
    check("rst_perr", parity_err, 0);
    rst_n = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    repeat (2) tick();
    bit_valid = 1'b0;
    check("idle_ignore_busy", busy, 0);
    check("idle_ignore_phi", phi_v, 0);

    for (int i = 0; i < 4; i++)
      run_frame(tbl[i].frame, tbl[i].gap, tbl[i].restart_at, tbl[i].exp);

    // start in the commit cycle must not begin a new frame
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(FA, 60, 1'b0);
    send_parity(FA, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("cstart_phi", phi_v, FA);
    check("cstart_done", frame_done, 1);
    check("cstart_busy", busy, 0);
    tick();
    check("cstart_idle", busy, 0);
    model_phi = FA;

    // asynchronous reset mid-frame
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(FC, 30, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_phi", phi_v, 0);
    check("async_busy", busy, 0);
    check("async_idx", elem_idx, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    model_phi = '0;
    run_frame(FC, 1'b0, 0, FC);

`ifdef SYNAPSE_FRAME_PARITY_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    send_bits(FA, 60, 1'b0);
    send_parity(FA, 1'b1);
    check("perr_pulse", parity_err, 1);
    check("perr_done", frame_done, 0);
    check("perr_busy", busy, 0);
    check("perr_phi", phi_v, model_phi);
    tick();
    check("perr_once", parity_err, 0);
    check("perr_nodone", frame_done, 0);
    run_frame(FA, 1'b0, 0, FA);
`endif

    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(0, 3)) begin
        bit_valid = 1'(($urandom % 2));
        bit_in    = 1'(($urandom % 2));
        tick();
        check("rnd_idle_done", frame_done, 0);
        check("rnd_idle_busy", busy, 0);
        check("rnd_idle_phi", phi_v, model_phi);
      end
      start     = 1'b1;
      bit_valid = 1'b1;
      bit_in    = 1'(($urandom % 2));
      tick();
      start     = 1'b0;
      bit_valid = 1'b0;
      fr = '0;
      n  = 0;
      while (n < 60) begin
        if ($urandom_range(0, 49) == 0) begin
          start = 1'b1;
          tick();
          start = 1'b0;
          n = 0;
          check("rnd_restart_busy", busy, 1);
          continue;
        end
        bv = ($urandom_range(0, 3) != 0);
        b  = 1'(($urandom % 2));
        bit_valid = bv;
        bit_in    = b;
        if (bv) begin
          fr[59-n] = b;
          n++;
        end
        tick();
        bit_valid = 1'b0;
        if (n < 60) check("rnd_idx", elem_idx, n / 4);
        check("rnd_phi_hold", phi_v, model_phi);
        check("rnd_busy", busy, 1);
      end
      send_parity(fr, 1'b0);
      tick();
      check("rnd_phi", phi_v, fr);
      check("rnd_done", frame_done, 1);
      check("rnd_busy_drop", busy, 0);
      model_phi = fr;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
